// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner: synchronise, debounce and arbitrate four coin
// buttons into one-hot single-cycle coin strobes with saturating counters.
module coin_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 8,
  parameter int CNT_W           = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Enable,
  input  logic             OneDollarIn,
  input  logic             FiftyCentsIn,
  input  logic             TenCentsIn,
  input  logic             FiveCentsIn,
  output logic             CoinValid,
  output logic [3:0]       Coins,
  output logic [7:0]       CoinValue,
  output logic             Reject,
  output logic [CNT_W-1:0] AcceptCount,
  output logic [CNT_W-1:0] RejectCount
);

  localparam int DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW =
    (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HO_LOAD = HW'(HOLDOFF_CYCLES);
  localparam logic [HW-1:0] HO_ONE  = HW'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RELEASE,
    HOLDOFF
  } state_t;

  logic [3:0]    raw;
  logic [3:0]    s1;
  logic [3:0]    s2;
  logic [3:0]    db;
  logic [DW-1:0] cnt [4];
  logic [HW-1:0] hcnt;
  logic          db_any;
  logic          db_one;
  state_t        state;

  assign raw    = {OneDollarIn, FiftyCentsIn, TenCentsIn, FiveCentsIn};
  assign db_any = |db;
  assign db_one = db_any && ((db & (db - 4'd1)) == 4'd0);

  function automatic logic [7:0] cents(input logic [3:0] c);
    logic [7:0] v;
    v = 8'd0;
    unique case (1'b1)
      c[3]:    v = 8'd100;
      c[2]:    v = 8'd50;
      c[1]:    v = 8'd10;
      c[0]:    v = 8'd5;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  // A level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      hcnt        <= '0;
      CoinValid   <= 1'b0;
      Coins       <= '0;
      CoinValue   <= '0;
      Reject      <= 1'b0;
      AcceptCount <= '0;
      RejectCount <= '0;
    end else begin
      CoinValid <= 1'b0;
      Coins     <= '0;
      CoinValue <= '0;
      Reject    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!Enable) begin
            if (db_any) state <= WAIT_RELEASE;
          end else if (db_one) begin
            CoinValid <= 1'b1;
            Coins     <= db;
            CoinValue <= cents(db);
            state     <= WAIT_RELEASE;
            if (AcceptCount != '1)
              AcceptCount <= AcceptCount + 1'b1;
          end else if (db_any) begin
            Reject <= 1'b1;
            state  <= WAIT_RELEASE;
            if (RejectCount != '1)
              RejectCount <= RejectCount + 1'b1;
          end
        end
        WAIT_RELEASE: begin
          if (!db_any && Enable) begin
            if (HOLDOFF_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              hcnt  <= HO_LOAD;
              state <= HOLDOFF;
            end
          end
        end
        HOLDOFF: begin
          // Any activity during holdoff restarts the release wait.
          if (db_any || !Enable) begin
            state <= WAIT_RELEASE;
          end else if (hcnt <= HO_ONE) begin
            state <= IDLE;
          end else begin
            hcnt <= hcnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
